uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, replacing the fixed 7-bit, single-shot transmitter used by the temperature-report path. Producers push words through a valid/ready handshake. The block serialises them LSB-first with a configurable data width, parity mode and stop-bit count, running back-to-back frames while the FIFO is non-empty. It sits between any sensor or status producer and the board TX pin.

## Interface
- CLK_HZ, 50_000_000 — input clock frequency.
- BAUD, 115_200 — line rate. Derived CLKS_PER_BIT = CLK_HZ/BAUD (integer division). Elaboration error if CLKS_PER_BIT < 2.
- DATA_BITS, 8 — payload width, legal range 5..9.
- PARITY_MODE, PARITY_NONE — one of PARITY_NONE, PARITY_EVEN, PARITY_ODD.
- STOP_BITS, 1 — 1 or 2.
- FIFO_DEPTH, 8 — power of two, ≥2.
- clk  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer has a word.
- wr_data  in  DATA_BITS  word to transmit.
- wr_ready  out  1  FIFO can accept a word; equals !full.
- tx  out  1  serial line, idle high.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued.

## Operation
- Write handshake: a word is accepted on a rising edge where wr_valid && wr_ready. If wr_valid is held while wr_ready is low, the word is not lost; it is accepted on the first edge where wr_ready is high. There is no overflow path.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head, load the shift register, compute parity, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out DATA_BITS bits LSB-first, each held CLKS_PER_BIT cycles. Go to PARITY if PARITY_MODE ≠ NONE, else go to STOP.
  - PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse. Held one bit time.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Counters: the baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change. The bit index counts 0..DATA_BITS-1; the stop index counts 0..STOP_BITS-1.
- Pop happens only in the IDLE→START or STOP→START transition cycle. The word is latched at pop; later FIFO writes never disturb an in-flight frame.
- Full FIFO with a simultaneous pop: wr_ready stays low that cycle (no write-through-on-pop). wr_ready rises the following cycle.
- Empty FIFO with a simultaneous write: no bypass. The word enters the FIFO and is popped on the next edge.
- fifo_count: +1 on accept, −1 on pop, unchanged when both occur on the same edge.
- Reset mid-frame: the frame is aborted immediately. The FIFO is emptied and tx returns high asynchronously. The truncated frame is not retransmitted.

## Timing
- Reset values: tx=1, busy=0, wr_ready=1, fifo_count=0, state=IDLE, all counters 0.
- Latency from idle and empty: for a word accepted at edge k, the pop occurs at edge k+1. tx falls and busy rises after edge k+1.
- Frame length: CLKS_PER_BIT×(1+DATA_BITS+P+STOP_BITS) cycles, where P=1 if parity is enabled, else 0.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- busy falls on the edge after the last stop-bit cycle, and only if the FIFO is empty.
- All outputs are registered. wr_ready is derived combinationally from the registered count.

## Structure
- Package uart_pkg holds:
  - parity_mode_e (PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2);
  - the tx_state_e enum;
  - function clks_per_bit(CLK_HZ, BAUD).
- Sub-module sync_fifo, parameters WIDTH and DEPTH:
  - ports clk, RST, push, push_data, pop, pop_data, full, empty, count;
  - pop_data is the combinational head word (show-ahead).
- The top level contains the FSM, the baud/bit counters, the shift register and the parity logic.

## Test plan
All scenarios use CLK_HZ=50_000_000 and BAUD=2_500_000 (CLKS_PER_BIT=20), with a 20 ns clk.
- 8N1, write 0x48 while idle. Required: tx low from edge k+1 for 20 cycles. Data bits 0,0,0,1,0,0,1,0, each 20 cycles. Stop high for 20 cycles. busy high for exactly 200 cycles.
- 8E1 with 0x48, then 8O1 with 0x48. Required: parity bit 0 (even), then 1 (odd). Frame length 220 cycles.
- 7N2 (DATA_BITS=7) with 0x5A. Required: 7 data bits 0,1,0,1,1,0,1. Stop high for 40 cycles. Frame length 200 cycles.
- Burst of 10 writes with FIFO_DEPTH=8 and wr_valid held high. Required: wr_ready drops when fifo_count=8. All 10 words are sent in order with zero idle cycles between frames. Final fifo_count=0.
- Assert RST 50 cycles into the DATA state with 3 words queued. Required: tx=1, busy=0 and fifo_count=0 immediately. A following write of 0x01 produces one clean frame.
- Write on the exact cycle the last stop bit ends while 1 word is queued. Required: the queued word starts with no gap. The new word follows, also with no gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: pop_data always presents the head word.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // A push while full is refused even if a pop frees a slot on the same edge.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a FIFO; frames run back-to-back while words are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned  CLK_HZ      = 50_000_000,
  parameter int unsigned  BAUD        = 115_200,
  parameter int unsigned  DATA_BITS   = 8,
  parameter parity_mode_e PARITY_MODE = PARITY_NONE,
  parameter int unsigned  STOP_BITS   = 1,
  parameter int unsigned  FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            RST,
  input  logic                            wr_valid,
  input  logic [DATA_BITS-1:0]            wr_data,
  output logic                            wr_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int unsigned CPB        = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned BAUD_W     = (CPB < 2) ? 1 : $clog2(CPB);
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);
  localparam bit          HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam bit          ODD_PARITY = (PARITY_MODE == PARITY_ODD);

  if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_e              state, state_n;
  logic [BAUD_W-1:0]      baud_cnt, baud_n;
  logic [BIT_W-1:0]       bit_idx, bit_n;
  logic                   stop_idx, stop_n;
  logic [DATA_BITS-1:0]   shreg, sh_n;
  logic                   par_bit, par_n;
  logic                   tx_n;
  logic                   pop;
  logic [DATA_BITS-1:0]   head;
  logic                   full;
  logic                   empty;
  logic                   bit_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .RST       (RST),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign wr_ready = !full;
  assign bit_end  = (baud_cnt == BAUD_W'(CPB - 1));

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + BAUD_W'(1);
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    sh_n    = shreg;
    par_n   = par_bit;
    pop     = 1'b0;
    tx_n    = 1'b1;

    case (state)
      IDLE: begin
        baud_n = '0;
        pop    = !empty;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            state_n = HAS_PARITY ? PARITY : STOP;
            stop_n  = 1'b0;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
            sh_n  = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          baud_n  = '0;
          stop_n  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_n = IDLE;
            stop_n  = 1'b0;
            pop     = !empty;
          end else begin
            stop_n = stop_idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Both pop points share one load path so back-to-back frames skip IDLE.
    if (pop) begin
      state_n = START;
      baud_n  = '0;
      bit_n   = '0;
      stop_n  = 1'b0;
      sh_n    = head;
      par_n   = (^head) ^ ODD_PARITY;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      shreg    <= sh_n;
      par_bit  <= par_n;
      tx       <= tx_n;
      busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameterisations share one line monitor and frame scoreboard.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  len;
    logic        gap0;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wv  = '0;
  logic [7:0] wd  = '0;
  logic [3:0] rdy, txs, bsy;
  logic [3:0] fc [4];
  logic       tx_line;

  int vectors     = 0;
  int miscompares = 0;
  frame_t sb[$];
  int nd [4] = '{8, 8, 8, 7};
  int pm [4] = '{0, 1, 2, 0};
  int ns [4] = '{1, 1, 1, 2};

  bit     mon_active = 1'b0;
  bit     bit_ok     = 1'b1;
  bit     saw_full   = 1'b0;
  int     cyc        = 0;
  int     gap        = 1000;
  frame_t cur;

  assign tx_line = &txs;

  always #10 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(2_500_000), .DATA_BITS(8),
                 .PARITY_MODE(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(8)) u0 (
    .clk(clk), .RST(rst), .wr_valid(wv[0]), .wr_data(wd),
    .wr_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .fifo_count(fc[0]));

  uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(2_500_000), .DATA_BITS(8),
                 .PARITY_MODE(PARITY_EVEN), .STOP_BITS(1), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .RST(rst), .wr_valid(wv[1]), .wr_data(wd),
    .wr_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .fifo_count(fc[1]));

  uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(2_500_000), .DATA_BITS(8),
                 .PARITY_MODE(PARITY_ODD), .STOP_BITS(1), .FIFO_DEPTH(8)) u2 (
    .clk(clk), .RST(rst), .wr_valid(wv[2]), .wr_data(wd),
    .wr_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .fifo_count(fc[2]));

  uart_tx_fifo #(.CLK_HZ(50_000_000), .BAUD(2_500_000), .DATA_BITS(7),
                 .PARITY_MODE(PARITY_NONE), .STOP_BITS(2), .FIFO_DEPTH(8)) u3 (
    .clk(clk), .RST(rst), .wr_valid(wv[3]), .wr_data(wd[6:0]),
    .wr_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]), .fifo_count(fc[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk_frame(input int u, input logic [7:0] d, input bit g0);
    frame_t f;
    int     p;
    logic   par;
    par       = 1'b0;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < nd[u]; i++) begin
      f.bits[1+i] = d[i];
      par ^= d[i];
    end
    p = 1 + nd[u];
    if (pm[u] != 0) begin
      f.bits[p] = (pm[u] == 2) ? ~par : par;
      p++;
    end
    f.len  = 5'(p + ns[u]);
    f.gap0 = g0;
    return f;
  endfunction

  // Line monitor: every cycle of a frame must match the expected bit; one check per bit time.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      gap        = 1000;
    end else begin
      if (!mon_active && tx_line === 1'b0) begin
        chk("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          if (cur.gap0) chk("no_idle_gap", gap, 0);
          mon_active = 1'b1;
          cyc        = 0;
          bit_ok     = 1'b1;
        end
      end else if (!mon_active && gap < 1000) begin
        gap++;
      end
      if (mon_active) begin
        if (tx_line !== cur.bits[cyc/20]) bit_ok = 1'b0;
        if (cyc % 20 == 19) begin
          chk($sformatf("frame_bit%0d", cyc / 20), bit_ok, 1);
          bit_ok = 1'b1;
        end
        cyc++;
        if (cyc == 20 * int'(cur.len)) begin
          mon_active = 1'b0;
          gap        = 0;
        end
      end
    end
  end

  // Holds wr_valid high until accepted; returns 1 ns after the accepting edge with valid still high.
  task automatic push_word(input int u, input logic [7:0] d, input bit g0);
    int n;
    n     = 0;
    wv[u] = 1'b1;
    wd    = d;
    if (!rdy[u]) begin
      saw_full = 1'b1;
      chk("ready_low_only_when_full", fc[u], 8);
    end
    while (!rdy[u] && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_within_bound", rdy[u], 1);
    @(posedge clk);
    sb.push_back(mk_frame(u, d, g0));
    #1;
  endtask

  task automatic frame_len(input int u, input int exp_n);
    int n;
    n = 1;
    chk("tx_idle_before_pop", txs[u], 1);
    chk("busy_low_before_pop", bsy[u], 0);
    @(posedge clk); #1;
    chk("tx_low_after_pop", txs[u], 0);
    chk("busy_high_after_pop", bsy[u], 1);
    while (bsy[u] && n < 1000) begin
      @(posedge clk); #1;
      if (bsy[u]) n++;
    end
    chk("busy_cycles", n, exp_n);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_active || bsy != 4'b0) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("monitor_idle", mon_active, 0);
    chk("fifo_count_zero", fc[0], 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", txs[0], 1);
    chk("rst_busy", bsy[0], 0);
    chk("rst_wr_ready", rdy[0], 1);
    chk("rst_fifo_count", fc[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8N1, 8E1, 8O1 with 0x48 and 7N2 with 0x5A, each from idle
    push_word(0, 8'h48, 1'b0); wv[0] = 1'b0; frame_len(0, 200); wait_idle();
    push_word(1, 8'h48, 1'b0); wv[1] = 1'b0; frame_len(1, 220); wait_idle();
    push_word(2, 8'h48, 1'b0); wv[2] = 1'b0; frame_len(2, 220); wait_idle();
    push_word(3, 8'h5A, 1'b0); wv[3] = 1'b0; frame_len(3, 200); wait_idle();

    // burst of ten writes with valid held; frames must run without gaps
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) push_word(0, 8'($urandom_range(0, 255)), i != 0);
    wv[0] = 1'b0;
    chk("burst_saw_full", saw_full, 1);
    wait_idle();

    // write landing on the last stop-bit edge while one word is queued
    push_word(0, 8'hA5, 1'b0);
    push_word(0, 8'h3C, 1'b1);
    wv[0] = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    push_word(0, 8'hC3, 1'b1);
    wv[0] = 1'b0;
    chk("count_pop_and_push", fc[0], 1);
    chk("next_start_no_gap", txs[0], 0);
    wait_idle();

    // reset 50 cycles into DATA with three words queued
    for (int i = 0; i < 4; i++) push_word(0, 8'(8'h11 * (i + 1)), i != 0);
    wv[0] = 1'b0;
    repeat (68) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_tx", txs[0], 1);
    chk("abort_busy", bsy[0], 0);
    chk("abort_fifo_count", fc[0], 0);
    chk("abort_wr_ready", rdy[0], 1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_word(0, 8'h01, 1'b0); wv[0] = 1'b0; frame_len(0, 200); wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
